// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and widths for the seven-segment display arbiter.
package seg_arb_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;
    localparam int WORD_W     = NUM_DIGITS * DIGIT_W;

    // IDLE: display blanked, nobody owns it. SHOW: one requester owns the display.
    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } seg_arb_state_e;

endpackage

// File: rtl/seg_display_arbiter_picker.sv
// Round-robin priority search: first set request at or above start_i, wrapping.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    localparam int unsigned N_U = N_REQ;

    int unsigned start_u;

    // Walk offsets 0..N-1 from the start index; constant-indexed compare keeps selects static.
    always_comb begin
        start_u  = 32'(start_i);
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            for (int unsigned k = 0; k < N_U; k++) begin
                if (!found_o && req_i[k] && (((start_u + i) % N_U) == k)) begin
                    found_o = 1'b1;
                    idx_o   = IDX_W'(k);
                end
            end
        end
        for (int unsigned k = 0; k < N_U; k++) begin
            onehot_o[k] = found_o && (idx_o == IDX_W'(k));
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the 8-digit seven-segment display among N_REQ requesters.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*WORD_W-1:0]      hex_data,
    input  logic [N_REQ*NUM_DIGITS-1:0]  digit_en,
    output logic [N_REQ-1:0]             grant,
    output logic [WORD_W-1:0]            disp_hex,
    output logic [NUM_DIGITS-1:0]        turn_on,
    output logic                         active,
    output logic                         slot_end
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam int unsigned N_U = N_REQ;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    seg_arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]        gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0]       disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   ton_q, ton_d;
    logic                    active_q, active_d;
    logic                    slot_end_q, slot_end_d;

    logic [IDX_W-1:0]        gnt_nxt;
    logic [IDX_W-1:0]        pick_start;
    logic [N_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic                    switch_evt;

    logic [WORD_W-1:0]       pick_word, own_word;
    logic [NUM_DIGITS-1:0]   pick_mask, own_mask;

    // Index just above the current owner; the search from here reaches the owner last.
    always_comb begin
        gnt_nxt = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);
    end

    // IDLE searches from the round-robin pointer, SHOW from just past the owner.
    always_comb begin
        pick_start = (state_q == IDLE) ? rr_ptr_q : gnt_nxt;
    end

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i    (req),
        .start_i  (pick_start),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // Word/mask muxes for the search winner and for the current owner.
    always_comb begin
        pick_word = '0;
        pick_mask = '0;
        own_word  = '0;
        own_mask  = '0;
        for (int unsigned k = 0; k < N_U; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_word = hex_data[k*WORD_W +: WORD_W];
                pick_mask = digit_en[k*NUM_DIGITS +: NUM_DIGITS];
            end
            if (gnt_idx_q == IDX_W'(k)) begin
                own_word = hex_data[k*WORD_W +: WORD_W];
                own_mask = digit_en[k*NUM_DIGITS +: NUM_DIGITS];
            end
        end
    end

    // Slot ends on dwell expiry or owner release; both together are one event.
    always_comb begin
        switch_evt = (state_q == SHOW) && ((cnt_q == '0) || ((req & grant_q) == '0));
    end

    // Next-state: grant, dwell counter and display register updates.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        ton_d      = ton_q;
        active_d   = active_q;
        slot_end_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = SHOW;
                    grant_d   = pick_onehot;
                    gnt_idx_d = pick_idx;
                    cnt_d     = CNT_RELOAD;
                    disp_d    = pick_word;
                    ton_d     = pick_mask;
                    active_d  = 1'b1;
                end
            end
            SHOW: begin
                if (switch_evt) begin
                    slot_end_d = 1'b1;
                    rr_ptr_d   = gnt_nxt;
                    if (pick_found) begin
                        grant_d   = pick_onehot;
                        gnt_idx_d = pick_idx;
                        cnt_d     = CNT_RELOAD;
                        disp_d    = pick_word;
                        ton_d     = pick_mask;
                        active_d  = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        gnt_idx_d = '0;
                        cnt_d     = '0;
                        disp_d    = '0;
                        ton_d     = '0;
                        active_d  = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    disp_d = own_word;
                    ton_d  = own_mask;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gnt_idx_q  <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            ton_q      <= '0;
            active_q   <= 1'b0;
            slot_end_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            ton_q      <= ton_d;
            active_q   <= active_d;
            slot_end_q <= slot_end_d;
        end
    end

    assign grant    = grant_q;
    assign disp_hex = disp_q;
    assign turn_on  = ton_q;
    assign active   = active_q;
    assign slot_end = slot_end_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus randomized traffic against a slot model.
module tb_seg_display_arbiter;

    localparam int N = 4;
    localparam int H = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*32-1:0]   hex_data;
    logic [N*8-1:0]    digit_en;
    logic [N-1:0]      grant;
    logic [31:0]       disp_hex;
    logic [7:0]        turn_on;
    logic              active;
    logic              slot_end;

    int tests = 0;
    int fails = 0;

    // Model: owner index (-1 = nobody), cycles the owner has held the slot, rotation pointer.
    int          m_owner;
    int          m_age;
    int          m_ptr;
    logic [31:0] m_disp;
    logic [7:0]  m_ton;
    logic        m_se;

    seg_display_arbiter #(
        .N_REQ       (N),
        .HOLD_CYCLES (H)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .hex_data (hex_data),
        .digit_en (digit_en),
        .grant    (grant),
        .disp_hex (disp_hex),
        .turn_on  (turn_on),
        .active   (active),
        .slot_end (slot_end)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [N-1:0] r, input int from);
        for (int o = 0; o < N; o++) begin
            int k;
            k = (from + o) % N;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input int k);
        logic [N*32-1:0] t;
        t = hex_data >> (32 * k);
        return t[31:0];
    endfunction

    function automatic logic [7:0] mask_of(input int k);
        logic [N*8-1:0] t;
        t = digit_en >> (8 * k);
        return t[7:0];
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_ptr   = 0;
        m_disp  = '0;
        m_ton   = '0;
        m_se    = 1'b0;
    endtask

    task automatic model_take(input int w);
        m_owner = w;
        m_age   = 1;
        m_disp  = word_of(w);
        m_ton   = mask_of(w);
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_step();
        int w;
        m_se = 1'b0;
        if (reset) begin
            model_reset();
        end else if (m_owner < 0) begin
            w = search(req, m_ptr);
            if (w >= 0) model_take(w);
        end else if (m_age >= H || ((req >> m_owner) & 1) == 0) begin
            m_se  = 1'b1;
            m_ptr = (m_owner + 1) % N;
            w = search(req, m_ptr);
            if (w >= 0) begin
                model_take(w);
            end else begin
                m_owner = -1;
                m_age   = 0;
                m_disp  = '0;
                m_ton   = '0;
            end
        end else begin
            m_age  = m_age + 1;
            m_disp = word_of(m_owner);
            m_ton  = mask_of(m_owner);
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg = 4'(1) << m_owner;
        check("grant",    64'(grant),    64'(eg));
        check("disp_hex", 64'(disp_hex), 64'(m_disp));
        check("turn_on",  64'(turn_on),  64'(m_ton));
        check("active",   64'(active),   64'(m_owner >= 0));
        check("slot_end", 64'(slot_end), 64'(m_se));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        compare_model();
    endtask

    // Assert reset between edges, confirm outputs clear at once, hold across one edge, release.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_grant",    64'(grant),    64'(0));
        check("rst_turn_on",  64'(turn_on),  64'(0));
        check("rst_disp",     64'(disp_hex), 64'(0));
        check("rst_active",   64'(active),   64'(0));
        check("rst_slot_end", 64'(slot_end), 64'(0));
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        hex_data = '0;
        digit_en = '0;
        model_reset();
        repeat (2) step();
        reset = 1'b0;

        // Idle after reset with no requests.
        repeat (2) step();
        check("idle_grant", 64'(grant), 64'(0));
        check("idle_ton",   64'(turn_on), 64'(0));

        // Sole requester: one-edge latency, re-granted every H cycles with slot_end pulses.
        hex_data = {$urandom, $urandom, $urandom, $urandom};
        hex_data[2*32 +: 32] = 32'h1234_ABCD;
        digit_en = 32'($urandom);
        digit_en[2*8 +: 8] = 8'hFF;
        req = 4'b0100;
        step();
        check("single_grant", 64'(grant), 64'(4'b0100));
        check("single_disp",  64'(disp_hex), 64'(32'h1234_ABCD));
        check("single_ton",   64'(turn_on), 64'(8'hFF));
        check("single_se0",   64'(slot_end), 64'(0));
        for (int c = 1; c <= 8; c++) begin
            step();
            check("single_hold_grant", 64'(grant), 64'(4'b0100));
            check("single_hold_se",    64'(slot_end), 64'((c % 4) == 0));
        end
        req = '0;
        step();
        check("drop_idle_grant",  64'(grant), 64'(0));
        check("drop_idle_active", 64'(active), 64'(0));
        check("drop_idle_se",     64'(slot_end), 64'(1));

        // Early release in cycle 2 of a slot hands over immediately with a reloaded dwell.
        async_reset();
        req = 4'b0101;
        step();
        check("early_first", 64'(grant), 64'(4'b0001));
        step();
        req = 4'b0100;
        step();
        check("early_grant", 64'(grant), 64'(4'b0100));
        check("early_se",    64'(slot_end), 64'(1));
        for (int c = 1; c <= 4; c++) begin
            step();
            check("early_reload_se", 64'(slot_end), 64'(c == 4));
        end

        // Mid-slot request does not preempt; the wrap-around winner takes over at expiry.
        async_reset();
        req = 4'b0010;
        step();
        check("nopre_first", 64'(grant), 64'(4'b0010));
        step();
        req = 4'b0011;
        repeat (2) begin
            step();
            check("nopre_hold", 64'(grant), 64'(4'b0010));
        end
        step();
        check("nopre_switch", 64'(grant), 64'(4'b0001));
        req = 4'b0001;
        repeat (3) step();
        req = 4'b0000;
        step();
        check("expire_grant",  64'(grant), 64'(0));
        check("expire_active", 64'(active), 64'(0));
        check("expire_ton",    64'(turn_on), 64'(0));

        // All four requesting: strict rotation, each slot exactly H cycles.
        async_reset();
        req = 4'b1111;
        for (int c = 1; c <= 21; c++) begin
            step();
            check("rr_grant", 64'(grant), 64'(4'(1) << (((c - 1) / 4) % 4)));
            check("rr_se",    64'(slot_end), 64'(c > 1 && ((c - 1) % 4) == 0));
        end
        check("rr_mid_owner", 64'(grant), 64'(4'b0010));

        // Reset during a slot, then stay idle with no requests.
        async_reset();
        req = '0;
        repeat (3) step();
        check("post_rst_grant", 64'(grant), 64'(0));
        check("post_rst_ton",   64'(turn_on), 64'(0));

        // Randomized traffic with live data and occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(3) == 0) req = 4'($urandom);
                hex_data = {$urandom, $urandom, $urandom, $urandom};
                digit_en = 32'($urandom);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Time-shares the 8-digit seven-segment display (SevenSegmentControl: in7..in0 plus turn_on) among N_REQ requesters.
Each requester presents a 32-bit hex word and an 8-bit digit-enable mask.
The arbiter grants the display round-robin for a fixed dwell of HOLD_CYCLES clocks per slot.
It drives registered hex nibbles and turn_on into the display controller, and blanks all digits when no requester is active.

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_CYCLES, 50_000_000, dwell length of one grant slot in clocks (>= 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester display request, level-sensitive
hex_data  input  N_REQ*32  requester i word at [32i+31:32i]; nibble k drives digit k
digit_en  input  N_REQ*8  requester i mask at [8i+7:8i]; bit k enables digit k
grant  output  N_REQ  one-hot current owner; all-zero when idle
disp_hex  output  32  nibble k [4k+3:4k] feeds in_k of the display controller
turn_on  output  8  digit enables to the display controller
active  output  1  high while any grant is held
slot_end  output  1  one-cycle pulse on every slot termination (expiry or drop)

Behaviour:
- Interface: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset values: grant=0, disp_hex=0, turn_on=0, active=0, slot_end=0, state=IDLE, rr_ptr=0, dwell counter=0.
- Reset asserted mid-slot clears everything immediately, with no slot_end pulse.
- State machine has two states, IDLE and SHOW.
- IDLE:
  - If req != 0 at a rising edge, pick the winner: the first set req bit searching upward from rr_ptr, wrapping.
  - On that same edge: grant <= onehot(winner), state <= SHOW, counter <= HOLD_CYCLES-1, and load disp_hex/turn_on from the winner.
  - Latency from req to grant and valid display is 1 cycle.
- SHOW, each cycle:
  - disp_hex <= hex_data[gnt], turn_on <= digit_en[gnt]. This is live data with a 1-cycle register delay.
  - Counter decrements.
- Switch event in SHOW: counter==0, or req[gnt]==0 (early release).
- On a switch event:
  - slot_end pulses for one cycle, coincident with the new grant.
  - rr_ptr <= gnt+1 mod N_REQ.
  - Winner is searched from gnt+1 upward, wrapping, and includes gnt itself last.
  - If a winner exists: grant moves to it, the counter reloads, and the display loads the winner's data on the same edge.
  - If there is no winner: state <= IDLE, grant=0, active=0, turn_on=0, disp_hex=0.
- A sole continuous requester is re-granted every HOLD_CYCLES cycles. grant stays high; slot_end still pulses.
- Requests arriving mid-slot never preempt. They wait for the next switch event.
- Early release and expiry in the same cycle are treated as one switch event with one pulse.
- active = |grant. grant is never multi-hot.
- Counter width is $clog2(HOLD_CYCLES). It never wraps, because it reloads on every switch.
- No combinational path from inputs to outputs; every output is a flop.

Decomposition:
- Shared package seg_arb_pkg:
  - state enum {IDLE, SHOW}
  - NUM_DIGITS=8
  - DIGIT_W=4
  - WORD_W=32
- One sub-module, rr_priority_picker (combinational):
  - inputs: req vector, start index
  - outputs: one-hot winner, index, found flag
  - used for both the IDLE and switch-event searches
- Display word/mask selection reuses mux-style indexing; no new mux module.

Test Plan:
All scenarios use N_REQ=4 and HOLD_CYCLES=4.
- Reset: assert reset mid-SHOW with grant=0010 -> outputs zero in the same cycle; after release with req=0, grant stays 0000 and turn_on=00.
- Single request: req=0100, hex_data[2]=32'h1234_ABCD, digit_en[2]=8'hFF -> one edge later grant=0100, disp_hex=1234ABCD, turn_on=FF; slot_end pulses every 4 cycles with grant unchanged.
- Round-robin: req=1111 held from IDLE -> grant sequence 0001,0010,0100,1000,0001, each held exactly 4 cycles, slot_end on each change.
- Early drop: grant=0001, req[0] drops in cycle 2 of the slot with req=0101 -> next edge grant=0100, counter reloaded, one slot_end.
- Expiry with no other requester and req dropped at the expiry edge -> grant=0000, active=0, turn_on=00.
- No preemption: grant=0010, req[0] rises mid-slot -> grant=0010 until expiry, then grant=0001 if req[2], req[3]=0.
